// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch stage.
// State encoding, default PC step, data_OUT field layout, counter helper.
package ifetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    PUSH = 2'd2,
    DROP = 2'd3
  } ifetch_state_e;

  localparam int DEF_PC_STEP = 4;
  localparam int PERF_WIDTH = 32;

  // data_OUT is {pc, instr}: instr at bit 0, pc directly above it
  localparam int DATA_INSTR_LSB = 0;

  function automatic int data_pc_lsb(input int instr_width);
    return DATA_INSTR_LSB + instr_width;
  endfunction

  function automatic logic [PERF_WIDTH-1:0] sat_inc(
    input logic [PERF_WIDTH-1:0] v,
    input logic ev
  );
    return (ev && (v != '1)) ? v + PERF_WIDTH'(1) : v;
  endfunction

endpackage

// File: rtl/ifetch_perf.sv
// ifetch_perf: four saturating event counters for the fetch stage.
// Only instantiated when IFETCH_PERF_EN is defined.
module ifetch_perf
  import ifetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetched_ev,
  input  logic                  full_stall_ev,
  input  logic                  dropped_ev,
  input  logic                  redirect_ev,
  output logic [PERF_WIDTH-1:0] fetched_cnt,
  output logic [PERF_WIDTH-1:0] full_stall_cnt,
  output logic [PERF_WIDTH-1:0] dropped_cnt,
  output logic [PERF_WIDTH-1:0] redirect_cnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_cnt    <= '0;
      full_stall_cnt <= '0;
      dropped_cnt    <= '0;
      redirect_cnt   <= '0;
    end else begin
      fetched_cnt    <= sat_inc(fetched_cnt, fetched_ev);
      full_stall_cnt <= sat_inc(full_stall_cnt, full_stall_ev);
      dropped_cnt    <= sat_inc(dropped_cnt, dropped_ev);
      redirect_cnt   <= sat_inc(redirect_cnt, redirect_ev);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: walks the PC, one imem read in flight, pushes {pc, instr}.
// Define IFETCH_PERF_EN to add saturating performance counters.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    PC_STEP     = DEF_PC_STEP
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              redirect_IN,
  input  logic [ADDR_WIDTH-1:0]             redirectPC_IN,
  output logic                              imemReq_OUT,
  output logic [ADDR_WIDTH-1:0]             imemAddr_OUT,
  input  logic                              imemValid_IN,
  input  logic [INSTR_WIDTH-1:0]            imemData_IN,
  input  logic                              fullFlag_IN,
  output logic                              pushReq_OUT,
  output logic [ADDR_WIDTH+INSTR_WIDTH-1:0] data_OUT
`ifdef IFETCH_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0]             perfFetched_OUT,
  output logic [PERF_WIDTH-1:0]             perfFullStall_OUT,
  output logic [PERF_WIDTH-1:0]             perfDropped_OUT,
  output logic [PERF_WIDTH-1:0]             perfRedirect_OUT
`endif
);

  localparam int InstrLsb = DATA_INSTR_LSB;
  localparam int PcLsb    = data_pc_lsb(INSTR_WIDTH);

  ifetch_state_e                      state, state_n;
  logic [ADDR_WIDTH-1:0]              pc, pc_n;
  logic                               req_n;
  logic [ADDR_WIDTH-1:0]              addr_n;
  logic                               push_n;
  logic [ADDR_WIDTH+INSTR_WIDTH-1:0]  data_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= REQ;
      pc           <= RESET_PC;
      imemReq_OUT  <= 1'b0;
      imemAddr_OUT <= '0;
      pushReq_OUT  <= 1'b0;
      data_OUT     <= '0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      imemReq_OUT  <= req_n;
      imemAddr_OUT <= addr_n;
      pushReq_OUT  <= push_n;
      data_OUT     <= data_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = 1'b0;
    addr_n  = imemAddr_OUT;
    push_n  = pushReq_OUT;
    data_n  = data_OUT;
    if (redirect_IN) begin
      // a pending push is flushed by the queue, never retried
      pc_n   = redirectPC_IN;
      push_n = 1'b0;
      unique case (state)
        WAIT:    state_n = imemValid_IN ? REQ : DROP;
        DROP:    state_n = imemValid_IN ? REQ : DROP;
        default: state_n = REQ;
      endcase
    end else begin
      unique case (state)
        REQ: begin
          req_n   = 1'b1;
          addr_n  = pc;
          state_n = WAIT;
        end
        WAIT: begin
          if (imemValid_IN) begin
            data_n[PcLsb +: ADDR_WIDTH]     = pc;
            data_n[InstrLsb +: INSTR_WIDTH] = imemData_IN;
            push_n  = 1'b1;
            state_n = PUSH;
          end
        end
        PUSH: begin
          if (!fullFlag_IN) begin
            push_n  = 1'b0;
            pc_n    = pc + ADDR_WIDTH'(PC_STEP);
            state_n = REQ;
          end
        end
        DROP: begin
          if (imemValid_IN) state_n = REQ;
        end
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  logic fetched_ev, full_stall_ev, dropped_ev;

  always_comb begin
    fetched_ev    = (state == PUSH) && !fullFlag_IN && !redirect_IN;
    full_stall_ev = (state == PUSH) && fullFlag_IN;
    dropped_ev    = imemValid_IN &&
                    ((state == DROP) || (redirect_IN && (state == WAIT)));
  end

  ifetch_perf u_perf (
    .clk            (clk),
    .reset          (reset),
    .fetched_ev     (fetched_ev),
    .full_stall_ev  (full_stall_ev),
    .dropped_ev     (dropped_ev),
    .redirect_ev    (redirect_IN),
    .fetched_cnt    (perfFetched_OUT),
    .full_stall_cnt (perfFullStall_OUT),
    .dropped_cnt    (perfDropped_OUT),
    .redirect_cnt   (perfRedirect_OUT)
  );
`else
  // counters absent; the fetch path above is identical in both builds
`endif

endmodule
